// File: rtl/imem_responder.sv
// Byte-addressed instruction memory behind a 2-entry in-order response FIFO.
// Fetches are read at the accept edge. Misaligned fetches return NOP_WORD
// with a misalign flag. A flush or reset discards every pending response.
// Memory contents survive reset.
module imem_responder #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_instr,
  output logic              resp_misalign,
  input  logic              resp_ready,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data
);

  logic [7:0] mem [0:(2**ADDR_W)-1];

  // slot0 is always the FIFO head; slot1 is only meaningful when occ == 2
  logic [1:0]        occ;
  logic [DATA_W-1:0] slot0_instr, slot1_instr;
  logic              slot0_mis, slot1_mis;

  logic              accept, pop, misalign;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [DATA_W-1:0] rd_word, new_instr;

  assign req_ready     = (occ != 2'd2);
  assign resp_valid    = (occ != 2'd0);
  assign resp_instr    = resp_valid ? slot0_instr : '0;
  assign resp_misalign = resp_valid & slot0_mis;

  assign accept   = req_valid & req_ready;
  assign pop      = resp_valid & resp_ready;
  assign misalign = (req_addr[1:0] != 2'b00);

  // Aligned word never crosses the top of memory, so the low two bits are
  // substituted instead of adding an offset.
  assign a0 = {req_addr[ADDR_W-1:2], 2'b00};
  assign a1 = {req_addr[ADDR_W-1:2], 2'b01};
  assign a2 = {req_addr[ADDR_W-1:2], 2'b10};
  assign a3 = {req_addr[ADDR_W-1:2], 2'b11};

  // Little-endian word read; sees pre-write bytes during a same-edge write
  assign rd_word   = {mem[a3], mem[a2], mem[a1], mem[a0]};
  assign new_instr = misalign ? NOP_WORD : rd_word;

  // Program-load byte writes, independent of handshake and flush; not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // FIFO occupancy and slot shifting; flush wins over same-cycle accept/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ         <= 2'd0;
      slot0_instr <= '0;
      slot0_mis   <= 1'b0;
      slot1_instr <= '0;
      slot1_mis   <= 1'b0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({accept, pop})
        2'b11: begin
          // accept implies occ < 2 and pop implies occ > 0, so occ == 1
          slot0_instr <= new_instr;
          slot0_mis   <= misalign;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            slot0_instr <= new_instr;
            slot0_mis   <= misalign;
          end else begin
            slot1_instr <= new_instr;
            slot1_mis   <= misalign;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0_instr <= slot1_instr;
          slot0_mis   <= slot1_mis;
          occ         <= occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed table-driven bench for imem_responder plus hand-written reset
// sequences.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, resp_ready, flush, wr_en;
  logic [7:0]  req_addr, wr_addr, wr_data;
  logic        req_ready, resp_valid, resp_misalign;
  logic [31:0] resp_instr;

  int checks = 0;
  int errors = 0;

  imem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_misalign(resp_misalign),
    .resp_ready(resp_ready), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rv;
    logic [7:0] ra;
    logic       rr;
    logic       fl;
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       e_ready;
    logic       e_valid;
    logic [31:0] e_instr;
    logic       e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic e_ready, input logic e_valid,
                            input logic [31:0] e_instr, input logic e_mis);
    check({name, ".req_ready"}, {31'd0, req_ready}, {31'd0, e_ready});
    check({name, ".resp_valid"}, {31'd0, resp_valid}, {31'd0, e_valid});
    check({name, ".resp_instr"}, resp_instr, e_instr);
    check({name, ".resp_misalign"}, {31'd0, resp_misalign}, {31'd0, e_mis});
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_addr = 0; resp_ready = 0; flush = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    idle_inputs();
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge clk);
  endtask

  // drive at negedge, sample 1 time unit after the following rising edge
  task automatic apply(input vec_t v);
    @(negedge clk);
    req_valid = v.rv; req_addr = v.ra; resp_ready = v.rr; flush = v.fl;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    @(posedge clk);
    #1;
    check_outs(v.name, v.e_ready, v.e_valid, v.e_instr, v.e_mis);
  endtask

  function automatic vec_t mk(string n, logic rv, logic [7:0] ra, logic rr, logic fl,
                              logic we, logic [7:0] wa, logic [7:0] wd,
                              logic er, logic ev, logic [31:0] ei, logic em);
    vec_t v;
    v.name = n; v.rv = rv; v.ra = ra; v.rr = rr; v.fl = fl;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e_ready = er; v.e_valid = ev; v.e_instr = ei; v.e_mis = em;
    return v;
  endfunction

  localparam logic [31:0] W0  = 32'h00500513;
  localparam logic [31:0] W4  = 32'h00100593;
  localparam logic [31:0] W8  = 32'h00200613;
  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    check_outs("reset", 1'b1, 1'b0, 32'h0, 1'b0);

    // name, rv, ra, rr, fl, we, wa, wd, exp ready, valid, instr, mis
    vecs.push_back(mk("aligned_0",     1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 1, W0, 0));
    vecs.push_back(mk("misalign_6",    1, 8'h06, 1, 0, 0, 8'h00, 8'h00, 1, 1, NOP, 1));
    vecs.push_back(mk("drain",         0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));
    vecs.push_back(mk("bp_acc0",       1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 1, W0, 0));
    vecs.push_back(mk("bp_acc4_full",  1, 8'h04, 0, 0, 0, 8'h00, 8'h00, 0, 1, W0, 0));
    vecs.push_back(mk("bp_held8",      1, 8'h08, 0, 0, 0, 8'h00, 8'h00, 0, 1, W0, 0));
    vecs.push_back(mk("bp_pop0",       1, 8'h08, 1, 0, 0, 8'h00, 8'h00, 1, 1, W4, 0));
    vecs.push_back(mk("bp_pop4_acc8",  1, 8'h08, 1, 0, 0, 8'h00, 8'h00, 1, 1, W8, 0));
    vecs.push_back(mk("hold8",         0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 1, W8, 0));
    vecs.push_back(mk("fill2",         1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, W8, 0));
    vecs.push_back(mk("flush_full",    1, 8'h04, 1, 1, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));
    vecs.push_back(mk("after_flush",   0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));
    vecs.push_back(mk("pop_empty",     0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));
    vecs.push_back(mk("occ1",          1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 1, W0, 0));
    vecs.push_back(mk("flush_occ1",    1, 8'h04, 0, 1, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));
    vecs.push_back(mk("wr_same_cycle", 1, 8'h00, 1, 0, 1, 8'h00, 8'hFF, 1, 1, W0, 0));
    vecs.push_back(mk("wr_next_read",  1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 1, 32'h005005FF, 0));
    vecs.push_back(mk("drain2",        0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));
    vecs.push_back(mk("wr_with_flush", 0, 8'h00, 1, 1, 1, 8'h01, 8'hAA, 1, 0, 32'h0, 0));
    vecs.push_back(mk("read_flush_wr", 1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 1, 32'h0050AAFF, 0));
    vecs.push_back(mk("drain3",        0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));

    // program load while in reset would be fine too; load after release
    @(negedge clk);
    rst = 0;
    write_byte(8'h00, 8'h13); write_byte(8'h01, 8'h05);
    write_byte(8'h02, 8'h50); write_byte(8'h03, 8'h00);
    write_byte(8'h04, 8'h93); write_byte(8'h05, 8'h05);
    write_byte(8'h06, 8'h10); write_byte(8'h07, 8'h00);
    write_byte(8'h08, 8'h13); write_byte(8'h09, 8'h06);
    write_byte(8'h0A, 8'h20); write_byte(8'h0B, 8'h00);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check_outs("loaded_idle", 1'b1, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // asynchronous reset pulse between edges with one response pending
    apply(mk("pre_rst_occ1", 1, 8'h04, 0, 0, 0, 8'h00, 8'h00, 1, 1, W4, 0));
    #2;
    rst = 1;
    #1;
    check_outs("async_rst", 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    rst = 0;
    // first edge after release accepts a new request; old 0x04 entry is gone
    apply(mk("post_rst_req",  1, 8'h08, 1, 0, 0, 8'h00, 8'h00, 1, 1, W8, 0));
    apply(mk("post_rst_mem",  1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 1, 32'h0050AAFF, 0));
    apply(mk("post_rst_empty", 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 32'h0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
